// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array job controller.
// Holds the FSM state encoding, default sizes and derived widths.
package systolic_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ROWS_DEF       = 4;
    localparam int COLS_DEF       = 4;
    localparam int K_MAX_DEF      = 256;
    localparam int TIMEOUT_DEF    = 1024;

    localparam int K_W   = $clog2(K_MAX_DEF + 1);
    localparam int COL_W = $clog2(COLS_DEF);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_FEED      = 4'd2,
        ST_WAIT_ACK  = 4'd3,
        ST_LAST      = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_DRAIN_SEL = 4'd6,
        ST_DRAIN_CAP = 4'd7,
        ST_FINISH    = 4'd8
    } ctrl_state_t;

endpackage

// File: rtl/systolic_array_controller_watchdog.sv
// Wait-state watchdog: counts enabled cycles, clears on request.
// o_expire is combinational and rises on the TIMEOUT-th enabled cycle.
module ctrl_watchdog
    import systolic_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/systolic_array_controller.sv
// Sequences one matmul job: fetch/feed K beats, wait for PEs, drain columns.
// Every output is registered; beats advance only on beat_ack_i, drain on acc_valid_i.
module systolic_array_controller
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int COLS       = COLS_DEF,
    parameter int K_MAX      = K_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          start_i,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic                          op_rd_o,
    output logic [$clog2(K_MAX)-1:0]      op_addr_o,
    input  logic [ROWS*DATA_WIDTH-1:0]    a_col_i,
    input  logic [COLS*DATA_WIDTH-1:0]    b_row_i,
    output logic [ROWS*DATA_WIDTH-1:0]    west_o,
    output logic [COLS*DATA_WIDTH-1:0]    north_o,
    output logic                          feed_valid_o,
    output logic                          last_element_o,
    input  logic                          beat_ack_i,
    input  logic [ROWS*COLS-1:0]          pe_done_i,
    output logic [COLS-1:0]               select_acc_o,
    output logic [$clog2(COLS)-1:0]       drain_col_o,
    input  logic [ROWS*DATA_WIDTH-1:0]    acc_data_i,
    input  logic [ROWS-1:0]               acc_valid_i,
    output logic                          res_we_o,
    output logic [$clog2(COLS)-1:0]       res_col_o,
    output logic [ROWS*DATA_WIDTH-1:0]    res_data_o
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int AW = $clog2(K_MAX);
    localparam int CW = $clog2(COLS);

    ctrl_state_t   r_state, w_state_nxt;
    logic [KW-1:0] r_k, w_k_nxt;
    logic [KW-1:0] r_k_len, w_k_len_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic          w_err_nxt;
    logic          w_res_we_nxt;
    logic          w_wd_en;
    logic          w_wd_expire;

    assign w_wd_en = (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_DONE) ||
                     (r_state == ST_DRAIN_CAP);

    ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .i_en     (w_wd_en),
        .i_clr    (w_state_nxt != r_state),
        .o_expire (w_wd_expire)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_k_nxt      = r_k;
        w_k_len_nxt  = r_k_len;
        w_col_nxt    = r_col;
        w_err_nxt    = error_o;
        w_res_we_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_err_nxt = 1'b0;
                    if (k_len_i != '0) begin
                        w_k_len_nxt = k_len_i;
                        w_k_nxt     = '0;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_FINISH;
                    end
                end
            end
            ST_FETCH: w_state_nxt = ST_FEED;
            ST_FEED:  w_state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (w_wd_expire) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (beat_ack_i) begin
                    w_k_nxt     = r_k + KW'(1);
                    w_state_nxt = (r_k + KW'(1) == r_k_len) ? ST_LAST : ST_FETCH;
                end
            end
            ST_LAST: w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (w_wd_expire) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (&pe_done_i) begin
                    w_col_nxt   = '0;
                    w_state_nxt = ST_DRAIN_SEL;
                end
            end
            ST_DRAIN_SEL: w_state_nxt = ST_DRAIN_CAP;
            ST_DRAIN_CAP: begin
                // Timeout wins over a late valid so a stuck drain never writes.
                if (w_wd_expire) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (&acc_valid_i) begin
                    w_res_we_nxt = 1'b1;
                    if (r_col == CW'(COLS - 1)) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_col_nxt   = r_col + CW'(1);
                        w_state_nxt = ST_DRAIN_SEL;
                    end
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state        <= ST_IDLE;
            r_k            <= '0;
            r_k_len        <= '0;
            r_col          <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            op_rd_o        <= 1'b0;
            op_addr_o      <= '0;
            west_o         <= '0;
            north_o        <= '0;
            feed_valid_o   <= 1'b0;
            last_element_o <= 1'b0;
            select_acc_o   <= '0;
            drain_col_o    <= '0;
            res_we_o       <= 1'b0;
            res_col_o      <= '0;
            res_data_o     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_k            <= w_k_nxt;
            r_k_len        <= w_k_len_nxt;
            r_col          <= w_col_nxt;
            error_o        <= w_err_nxt;
            // done trails FINISH by a cycle, landing in IDLE where busy is already low.
            busy_o         <= (w_state_nxt != ST_IDLE);
            done_o         <= (r_state == ST_FINISH);
            op_rd_o        <= (w_state_nxt == ST_FETCH);
            last_element_o <= (w_state_nxt == ST_LAST);
            feed_valid_o   <= (r_state == ST_FEED);
            res_we_o       <= w_res_we_nxt;
            select_acc_o   <= (w_state_nxt == ST_DRAIN_SEL) ? (COLS'(1) << w_col_nxt) : '0;
            if (w_state_nxt == ST_FETCH) begin
                op_addr_o <= w_k_nxt[AW-1:0];
            end
            if (r_state == ST_FEED) begin
                west_o  <= a_col_i;
                north_o <= b_row_i;
            end
            if (w_state_nxt == ST_DRAIN_SEL) begin
                drain_col_o <= w_col_nxt;
            end
            if (w_res_we_nxt) begin
                res_col_o  <= r_col;
                res_data_o <= acc_data_i;
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_controller.sv
// Directed bench for a 2x2 controller with a small cycle-stepped PE/buffer model.
module tb_systolic_array_controller;

    localparam int DW = 32;
    localparam int R  = 2;
    localparam int C  = 2;
    localparam int KM = 256;
    localparam int TO = 1024;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic            start_i;
    logic [8:0]      k_len_i;
    logic            busy_o, done_o, error_o, op_rd_o;
    logic [7:0]      op_addr_o;
    logic [R*DW-1:0] a_col_i;
    logic [C*DW-1:0] b_row_i;
    logic [R*DW-1:0] west_o;
    logic [C*DW-1:0] north_o;
    logic            feed_valid_o, last_element_o, beat_ack_i;
    logic [R*C-1:0]  pe_done_i;
    logic [C-1:0]    select_acc_o;
    logic [0:0]      drain_col_o;
    logic [R*DW-1:0] acc_data_i;
    logic [R-1:0]    acc_valid_i;
    logic            res_we_o;
    logic [0:0]      res_col_o;
    logic [R*DW-1:0] res_data_o;

    systolic_array_controller #(
        .DATA_WIDTH(DW), .ROWS(R), .COLS(C), .K_MAX(KM), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .k_len_i(k_len_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .op_rd_o(op_rd_o), .op_addr_o(op_addr_o),
        .a_col_i(a_col_i), .b_row_i(b_row_i),
        .west_o(west_o), .north_o(north_o),
        .feed_valid_o(feed_valid_o), .last_element_o(last_element_o),
        .beat_ack_i(beat_ack_i), .pe_done_i(pe_done_i),
        .select_acc_o(select_acc_o), .drain_col_o(drain_col_o),
        .acc_data_i(acc_data_i), .acc_valid_i(acc_valid_i),
        .res_we_o(res_we_o), .res_col_o(res_col_o), .res_data_o(res_data_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-job observations
    int q_addr[$];
    int wr_col[$];
    logic [63:0] wr_dat[$];
    int wr_cyc[$];
    int n_feed, n_last, n_ack, acks_at_last, n_done, done_cyc, n_sel;
    int sel_first_cyc, sel1_n, sel1_cyc, pe_full_cyc, err_cyc, feed1_cyc;
    bit busy_at_done, fin;

    task automatic run_job(input int klen, input bit ack_en, input int pe_gap,
                           input int d1, input int budget);
        int ack_t, acc_t, pe_t, last_addr, dc;
        q_addr.delete(); wr_col.delete(); wr_dat.delete(); wr_cyc.delete();
        n_feed = 0; n_last = 0; n_ack = 0; acks_at_last = -1; n_done = 0; done_cyc = -1;
        n_sel = 0; sel_first_cyc = -1; sel1_n = 0; sel1_cyc = -1; pe_full_cyc = -1;
        err_cyc = -1; feed1_cyc = -1; busy_at_done = 1'b1; fin = 1'b0;
        ack_t = 0; acc_t = 0; pe_t = 0; last_addr = 0;
        @(negedge clk_i);
        start_i = 1'b1; k_len_i = 9'(klen);
        pe_done_i = '0; acc_valid_i = '0; beat_ack_i = 1'b0;
        for (int c = 1; c <= budget && !fin; c++) begin
            @(negedge clk_i);
            start_i    = 1'b0;
            beat_ack_i = 1'b0;
            if (ack_t > 0) begin
                ack_t--;
                if (ack_t == 0) begin beat_ack_i = 1'b1; n_ack++; end
            end
            if (op_rd_o) begin
                last_addr = int'(op_addr_o);
                q_addr.push_back(last_addr);
                a_col_i = {32'(last_addr*16 + 2),   32'(last_addr*16 + 1)};
                b_row_i = {32'(last_addr*16 + 258), 32'(last_addr*16 + 257)};
            end
            if (feed_valid_o) begin
                n_feed++;
                if (n_feed == 1) feed1_cyc = c;
                chk("west_data",  west_o,  {32'(last_addr*16 + 2),   32'(last_addr*16 + 1)});
                chk("north_data", north_o, {32'(last_addr*16 + 258), 32'(last_addr*16 + 257)});
                if (ack_en) ack_t = 2;
            end
            if (pe_t > 0) begin
                pe_t--;
                if (pe_t == 0) begin pe_done_i = '1; pe_full_cyc = c; end
            end
            if (last_element_o) begin
                n_last++;
                acks_at_last = n_ack;
                if (pe_gap == 0) begin
                    pe_done_i = '1; pe_full_cyc = c;
                end else begin
                    pe_done_i = 4'b0111; pe_t = pe_gap;
                end
            end
            if (res_we_o) begin
                wr_col.push_back(int'(res_col_o));
                wr_dat.push_back(res_data_o);
                wr_cyc.push_back(c);
                acc_valid_i = '0;
                acc_t = 0;
            end
            if (acc_t > 0) begin
                acc_t--;
                if (acc_t == 0) acc_valid_i = '1;
            end
            if (select_acc_o != '0) begin
                n_sel++;
                if (n_sel == 1) sel_first_cyc = c;
                chk("sel_onehot", 64'($onehot(select_acc_o)), 64'd1);
                if (select_acc_o == 2'b10) begin
                    sel1_n++; sel1_cyc = c;
                    if (d1 == 0) acc_valid_i = '1; else acc_t = d1;
                end else begin
                    acc_valid_i = '1;
                end
            end
            dc = int'(drain_col_o);
            acc_data_i = {32'(dc*16 + 32), 32'(dc*16 + 16)};
            if (done_o) begin
                n_done++; done_cyc = c; busy_at_done = busy_o; fin = 1'b1;
            end
            if (error_o) begin
                err_cyc = c; fin = 1'b1;
            end
        end
        chk("job_ended_in_budget", 64'(fin), 64'd1);
        pe_done_i = '0; acc_valid_i = '0; beat_ack_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  64'(busy_o), 64'd0);
        chk({tag, "_done"},  64'(done_o), 64'd0);
        chk({tag, "_err"},   64'(error_o), 64'd0);
        chk({tag, "_strb"},  64'({op_rd_o, feed_valid_o, last_element_o, res_we_o}), 64'd0);
        chk({tag, "_sel"},   64'(select_acc_o), 64'd0);
        chk({tag, "_west"},  west_o, 64'd0);
        chk({tag, "_resd"},  res_data_o, 64'd0);
        chk({tag, "_addr"},  64'(op_addr_o), 64'd0);
    endtask

    task automatic chk_drain(input string tag);
        chk({tag, "_nwr"}, 64'(wr_col.size()), 64'd2);
        if (wr_col.size() == 2) begin
            chk({tag, "_wr0_col"}, 64'(wr_col[0]), 64'd0);
            chk({tag, "_wr0_dat"}, wr_dat[0], {32'h20, 32'h10});
            chk({tag, "_wr1_col"}, 64'(wr_col[1]), 64'd1);
            chk({tag, "_wr1_dat"}, wr_dat[1], {32'h30, 32'h20});
            chk({tag, "_done_after_wr"}, 64'(done_cyc - wr_cyc[1]), 64'd1);
        end
        chk({tag, "_ndone"}, 64'(n_done), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    endtask

    initial begin
        rstn_i = 1'b0; start_i = 1'b0; k_len_i = '0; beat_ack_i = 1'b0;
        a_col_i = '0; b_row_i = '0; pe_done_i = '0; acc_data_i = '0; acc_valid_i = '0;
        repeat (3) @(negedge clk_i);
        chk_all_zero("reset");
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Full job, k_len=3, acks 2 cycles after each feed
        run_job(3, 1'b1, 0, 0, 400);
        chk("a_nrd", 64'(q_addr.size()), 64'd3);
        if (q_addr.size() == 3) begin
            chk("a_addr0", 64'(q_addr[0]), 64'd0);
            chk("a_addr1", 64'(q_addr[1]), 64'd1);
            chk("a_addr2", 64'(q_addr[2]), 64'd2);
        end
        chk("a_nfeed", 64'(n_feed), 64'd3);
        chk("a_nlast", 64'(n_last), 64'd1);
        chk("a_acks_at_last", 64'(acks_at_last), 64'd3);
        chk("a_sel_cycles", 64'(n_sel), 64'd2);
        chk("a_err", 64'(error_o), 64'd0);
        chk_drain("a");

        // Zero-length job goes straight to FINISH
        run_job(0, 1'b1, 0, 0, 20);
        chk("z_done_cyc", 64'(done_cyc), 64'd2);
        chk("z_nrd", 64'(q_addr.size()), 64'd0);
        chk("z_nfeed", 64'(n_feed), 64'd0);
        chk("z_nsel", 64'(n_sel), 64'd0);
        chk("z_nwr", 64'(wr_col.size()), 64'd0);

        // Ack withheld: watchdog trips after TIMEOUT cycles in WAIT_ACK
        run_job(2, 1'b0, 0, 0, 1200);
        chk("t_err", 64'(error_o), 64'd1);
        chk("t_busy", 64'(busy_o), 64'd0);
        chk("t_ndone", 64'(n_done), 64'd0);
        chk("t_err_delay", 64'(err_cyc - feed1_cyc), 64'd1024);
        @(negedge clk_i);
        chk("t_err_sticky", 64'(error_o), 64'd1);

        // New start clears error; PE done held one bit short for 100 cycles
        run_job(1, 1'b1, 100, 0, 600);
        chk("p_err_cleared", 64'(error_o), 64'd0);
        chk("p_acks_at_last", 64'(acks_at_last), 64'd1);
        chk("p_sel_after_full", 64'(sel_first_cyc - pe_full_cyc), 64'd1);
        chk_drain("p");

        // Column 1 accumulator valid delayed 5 cycles
        run_job(2, 1'b1, 0, 5, 600);
        chk("d_sel1_cycles", 64'(sel1_n), 64'd1);
        if (wr_cyc.size() == 2)
            chk("d_sel1_to_wr", 64'(wr_cyc[1] - sel1_cyc), 64'd6);
        chk_drain("d");

        // Async reset in the middle of FEED
        @(negedge clk_i);
        start_i = 1'b1; k_len_i = 9'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("r_fetch_rd", 64'(op_rd_o), 64'd1);
        @(negedge clk_i);
        chk("r_busy_pre", 64'(busy_o), 64'd1);
        rstn_i = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        run_job(2, 1'b1, 0, 0, 400);
        chk("r_nfeed", 64'(n_feed), 64'd2);
        chk("r_nlast", 64'(n_last), 64'd1);
        chk_drain("r");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_array_controller.md
Name: systolic_array_controller

Overview:
- Sequences one matrix-multiply job on a ROWS x COLS grid of processing elements (PEs).
- Fetches K operand beats from the operand buffers and injects them at the west and north array edges, one beat per handshake.
- Signals the last element, waits for every PE to report done, then drains accumulators column by column into the result buffer.
- Sits between the job/host interface and the PE grid.

Parameters:
- DATA_WIDTH, 32, operand/accumulator width.
- ROWS, 4, PE rows.
- COLS, 4, PE columns.
- K_MAX, 256, maximum inner dimension.
- TIMEOUT, 1024, watchdog cycles per wait state.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  job start; sampled only in IDLE.
- k_len_i  in  $clog2(K_MAX+1)  inner dimension; latched at start.
- busy_o  out  1  high when not in IDLE.
- done_o  out  1  one-cycle pulse at job end.
- error_o  out  1  sticky watchdog flag; cleared by the next accepted start.
- op_rd_o  out  1  operand read strobe.
- op_addr_o  out  $clog2(K_MAX)  beat index k.
- a_col_i  in  ROWS*DATA_WIDTH  A[.][k]; valid the cycle after op_rd_o.
- b_row_i  in  COLS*DATA_WIDTH  B[k][.]; valid the cycle after op_rd_o.
- west_o  out  ROWS*DATA_WIDTH  west edge data.
- north_o  out  COLS*DATA_WIDTH  north edge data.
- feed_valid_o  out  1  edge inputs_valid; one-cycle pulse per beat.
- last_element_o  out  1  one-cycle pulse after the final beat is acknowledged.
- beat_ack_i  in  1  AND of edge-PE passthrough_valid; beat consumed.
- pe_done_i  in  ROWS*COLS  per-PE done flags.
- select_acc_o  out  COLS  one-hot column accumulator select.
- drain_col_o  out  $clog2(COLS)  column index for the external east/valid mux.
- acc_data_i  in  ROWS*DATA_WIDTH  muxed east outputs of column drain_col_o.
- acc_valid_i  in  ROWS  muxed accumulator_valid of column drain_col_o.
- res_we_o  out  1  result write strobe.
- res_col_o  out  $clog2(COLS)  result column address.
- res_data_o  out  ROWS*DATA_WIDTH  result column data.

Behaviour:
- Reset state and values: state IDLE, k counter 0, column counter 0, watchdog 0; every output is 0.
- All outputs are registered.
- FSM: IDLE -> FETCH -> FEED -> WAIT_ACK -> (FETCH | LAST) -> WAIT_DONE -> DRAIN_SEL -> DRAIN_CAP -> (DRAIN_SEL | FINISH) -> IDLE.
- IDLE:
  - start_i with k_len_i>0: latch k_len, k=0, clear error_o, go FETCH.
  - start_i with k_len_i==0: go FINISH directly; no feed, no drain.
  - start_i while busy is ignored.
- FETCH: op_rd_o=1 with op_addr_o=k for one cycle.
- FEED: the cycle after FETCH, register a_col_i/b_row_i onto west_o/north_o and pulse feed_valid_o. Data is held stable until the next FEED.
- WAIT_ACK:
  - On beat_ack_i: k++.
  - If k==k_len-1 at ack, go LAST; else go FETCH.
  - Minimum beat period is 3 cycles plus PE latency.
- LAST: pulse last_element_o for one cycle, go WAIT_DONE.
- WAIT_DONE: leave when &pe_done_i; col=0.
- DRAIN_SEL:
  - select_acc_o = 1<<col for exactly one cycle.
  - drain_col_o = col, held through DRAIN_CAP.
- DRAIN_CAP:
  - On &acc_valid_i: res_we_o=1, res_col_o=col, res_data_o=acc_data_i.
  - If col==COLS-1, go FINISH; else col++ and go DRAIN_SEL.
- FINISH: pulse done_o, go IDLE. busy_o drops the same cycle done_o is high.
- Watchdog:
  - Counts cycles in WAIT_ACK, WAIT_DONE and DRAIN_CAP; resets on every state change.
  - On reaching TIMEOUT: set error_o, no done_o pulse, go IDLE; all strobes are 0 that cycle.
- Simultaneous events:
  - beat_ack_i while in FEED is ignored; an ack is only accepted in WAIT_ACK.
  - start_i in the same cycle as FINISH is ignored.
- Async reset mid-job: immediate return to reset values. Partial results are not written.
- Arithmetic: counters are unsigned. No accumulation is performed here.

Decomposition:
- Package systolic_pkg holds:
  - ctrl_state_t enum (9 states, 4-bit encoding).
  - Width localparams K_W=$clog2(K_MAX+1) and COL_W=$clog2(COLS).
  - TIMEOUT default.
- One natural sub-module: ctrl_watchdog, a counter with clear and expire outputs, parameterized by TIMEOUT.

Test Plan:
- 2x2 array, k_len=3, model acks 2 cycles after feed:
  - 3 op_rd_o at addr 0,1,2, then 3 feed_valid_o pulses.
  - last_element_o exactly once, after the 3rd ack.
  - done_o follows res_we_o writes to col 0 then col 1.
- k_len=0 start -> done_o pulse 2 cycles later; no op_rd_o, feed_valid_o, select_acc_o or res_we_o.
- Withhold beat_ack_i -> error_o=1 after 1024 cycles in WAIT_ACK, busy_o=0, no done_o. A new start clears error_o.
- pe_done_i lacking one bit for 100 cycles, then complete -> DRAIN_SEL occurs only after the final bit rises.
- Drain with acc_valid_i delayed 5 cycles on column 1:
  - res_data_o equals acc_data_i on the valid cycle (e.g. 0x0000_0010 / 0x0000_0020).
  - select_acc_o is one-hot 2'b10 for exactly 1 cycle.
- Assert rstn_i low mid-FEED -> all outputs 0 immediately; after release, start_i runs a full job correctly.
